word_uart_tx: RTL

//   Downstream stage of the capture controller: accepts one WIDTH-bit word per strobe
//   and transmits it to the host over a UART TX line (8N1).

---
 rtl/word_uart_tx_if.sv | 29 ++
 rtl/word_uart_tx.sv | 123 ++++++++++++
 2 files changed

// File: rtl/word_uart_tx_if.sv
// word_uart_tx_if: word handshake plus serial line between the capture
// controller (master) and the word UART transmitter (slave).
//   stb_i  master->slave  word valid strobe, single cycle
//   d_i    master->slave  word to transmit, sampled on stb_i && rdy_o
//   rdy_o  slave->master  transmitter idle, able to accept a word
//   tx_o   slave->master  UART serial output (idle high); exposed here so
//                         the host-side line travels with the handshake
interface word_uart_tx_if #(
  parameter int WIDTH = 32
);
  logic             stb_i;
  logic [WIDTH-1:0] d_i;
  logic             rdy_o;
  logic             tx_o;

  modport master (
    output stb_i,
    output d_i,
    input  rdy_o,
    input  tx_o
  );

  modport slave (
    input  stb_i,
    input  d_i,
    output rdy_o,
    output tx_o
  );
endinterface

// File: rtl/word_uart_tx.sv
// word_uart_tx: accepts one WIDTH-bit word per strobe and sends it out as
// NBYTES back-to-back 8N1 UART frames, least-significant byte first, bits
// LSB first. rdy_o stays low until the last stop bit has fully left the line.
// Ports:
//   clk_i   system clock
//   rst_in  asynchronous reset, active low (aborts any frame, line idles high)
//   bus     word_uart_tx_if slave: stb_i, d_i in; rdy_o, tx_o out (registered)
module word_uart_tx #(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           clk_i,
  input  logic           rst_in,
  word_uart_tx_if.slave  bus
);

  localparam int NBYTES = WIDTH / 8;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  shift_reg;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic              tx_q;
  logic              rdy_q;

  logic              baud_end;
  logic [2:0]        bit_nxt;

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign bit_nxt   = bit_cnt + 3'd1;

  assign bus.tx_o  = tx_q;
  assign bus.rdy_o = rdy_q;

  // tx_q is loaded with the level of the bit that starts on the same edge the
  // previous bit ends, so every level is held exactly CLKS_PER_BIT cycles and
  // the line never lags the state by a cycle.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      baud_cnt  <= '0;
      tx_q      <= 1'b1;
      rdy_q     <= 1'b1;
    end else begin
      if (state != IDLE) begin
        baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          // rdy_q is high throughout IDLE, so a strobe here is an accept.
          if (bus.stb_i) begin
            shift_reg <= bus.d_i;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            tx_q      <= 1'b0;
            rdy_q     <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (baud_end) begin
            bit_cnt <= '0;
            tx_q    <= shift_reg[0];
            state   <= DATA;
          end
        end

        DATA: begin
          if (baud_end) begin
            if (bit_cnt == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_nxt;
              tx_q    <= shift_reg[bit_nxt];
            end
          end
        end

        STOP: begin
          if (baud_end) begin
            if (byte_cnt != BYTE_LAST) begin
              // Next byte's start bit follows the stop bit with no gap.
              byte_cnt  <= byte_cnt + 1'b1;
              shift_reg <= shift_reg >> 8;
              tx_q      <= 1'b0;
              state     <= START;
            end else begin
              rdy_q <= 1'b1;
              state <= IDLE;
            end
          end
        end

        default: begin
          tx_q  <= 1'b1;
          rdy_q <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
